// File: rtl/ctrl_pkg.sv
// rtl/ctrl_pkg.sv - opcode, ALU code, strobe index and state definitions for datapath_ctrl
package ctrl_pkg;

  localparam logic [4:0] OP_ADD  = 5'b00000;
  localparam logic [4:0] OP_SUB  = 5'b00001;
  localparam logic [4:0] OP_AND  = 5'b00010;
  localparam logic [4:0] OP_OR   = 5'b00011;
  localparam logic [4:0] OP_NOT  = 5'b00100;
  localparam logic [4:0] OP_NEG  = 5'b00101;
  localparam logic [4:0] OP_NOP  = 5'b11010;
  localparam logic [4:0] OP_HALT = 5'b11011;

  localparam logic [15:0] ALU_INCPC = 16'd0;
  localparam logic [15:0] ALU_ADD   = 16'd1;
  localparam logic [15:0] ALU_SUB   = 16'd2;
  localparam logic [15:0] ALU_NOT   = 16'd3;
  localparam logic [15:0] ALU_AND   = 16'd4;
  localparam logic [15:0] ALU_OR    = 16'd5;
  localparam logic [15:0] ALU_NEG   = 16'd6;

  localparam int BIT_Z   = 19;
  localparam int BIT_PC  = 20;
  localparam int BIT_MDR = 21;

  typedef enum logic [2:0] {
    S_IDLE, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_HALT
  } state_t;

  typedef enum logic [2:0] {
    CLS_3OP, CLS_2OP, CLS_NOP, CLS_HALT, CLS_ILL
  } cls_t;

  typedef struct packed {
    cls_t        cls;
    logic [15:0] alu;
  } dec_t;

  function automatic dec_t decode_op(input logic [4:0] op);
    dec_t d;
    d.cls = CLS_ILL;
    d.alu = ALU_INCPC;
    case (op)
      OP_ADD:  begin d.cls = CLS_3OP; d.alu = ALU_ADD; end
      OP_SUB:  begin d.cls = CLS_3OP; d.alu = ALU_SUB; end
      OP_AND:  begin d.cls = CLS_3OP; d.alu = ALU_AND; end
      OP_OR:   begin d.cls = CLS_3OP; d.alu = ALU_OR;  end
      OP_NOT:  begin d.cls = CLS_2OP; d.alu = ALU_NOT; end
      OP_NEG:  begin d.cls = CLS_2OP; d.alu = ALU_NEG; end
      OP_NOP:  d.cls = CLS_NOP;
      OP_HALT: d.cls = CLS_HALT;
      default: d.cls = CLS_ILL;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/ctrl_decode.sv
// rtl/ctrl_decode.sv - combinational opcode to instruction class / ALU code / illegal flag
module ctrl_decode
  import ctrl_pkg::*;
(
  input  logic [4:0]  op_i,
  output cls_t        cls_o,
  output logic [15:0] alu_o,
  output logic        illegal_o
);

  dec_t dec;

  assign dec       = decode_op(op_i);
  assign cls_o     = dec.cls;
  assign alu_o     = dec.alu;
  assign illegal_o = (dec.cls == CLS_ILL);

endmodule

// File: rtl/datapath_ctrl.sv
// rtl/datapath_ctrl.sv - hardwired fetch/decode/execute control FSM for the 32-bit bus datapath
// Optional retired-instruction counter: DATAPATH_CTRL_RETIRE_COUNT_EN
module datapath_ctrl
  import ctrl_pkg::*;
#(
  parameter int RETIRE_W = 16
) (
  input  logic                clock,
  input  logic                clear,
  input  logic                run,
  input  logic [31:0]         ir,
  input  logic                mem_ready,
  output logic [31:0]         Rin,
  output logic [31:0]         Rout,
  output logic                IRin,
  output logic                MARin,
  output logic                RYin,
  output logic [15:0]         ALUControl,
  output logic                MDRread,
  output logic                busy,
  output logic                halted,
  output logic                illegal,
  output logic [RETIRE_W-1:0] retired
);

  state_t      state_q, state_d;
  logic        illegal_q, illegal_d;
  logic        retire;
  cls_t        dec_cls;
  logic [15:0] dec_alu;
  logic        dec_illegal;
  logic [3:0]  ra, rb, rc;

  assign ra = ir[26:23];
  assign rb = ir[22:19];
  assign rc = ir[18:15];

  ctrl_decode u_decode (
    .op_i      (ir[31:27]),
    .cls_o     (dec_cls),
    .alu_o     (dec_alu),
    .illegal_o (dec_illegal)
  );

  always_comb begin
    state_d   = state_q;
    illegal_d = illegal_q;
    retire    = 1'b0;
    case (state_q)
      S_IDLE: if (run) state_d = S_T0;
      S_T0:   state_d = S_T1;
      S_T1:   if (mem_ready) state_d = S_T2;
      S_T2:   state_d = S_T3;
      S_T3: begin
        if (dec_illegal) begin
          state_d   = S_HALT;
          illegal_d = 1'b1;
        end else if (dec_cls == CLS_NOP) begin
          state_d = S_T0;
          retire  = 1'b1;
        end else if (dec_cls == CLS_HALT) begin
          state_d = S_HALT;
        end else begin
          state_d = S_T4;
        end
      end
      S_T4: begin
        if (dec_cls == CLS_2OP) begin
          state_d = S_T0;
          retire  = 1'b1;
        end else begin
          state_d = S_T5;
        end
      end
      S_T5: begin
        state_d = S_T0;
        retire  = 1'b1;
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      state_q   <= S_IDLE;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      illegal_q <= illegal_d;
    end
  end

  // Strobes depend only on state and the latched IR; T1 gates the PC load on mem_ready.
  always_comb begin
    Rin        = '0;
    Rout       = '0;
    IRin       = 1'b0;
    MARin      = 1'b0;
    RYin       = 1'b0;
    MDRread    = 1'b0;
    ALUControl = ALU_INCPC;
    case (state_q)
      S_T0: begin
        Rout[BIT_PC] = 1'b1;
        MARin        = 1'b1;
        Rin[BIT_Z]   = 1'b1;
      end
      S_T1: begin
        Rout[BIT_Z]  = 1'b1;
        Rin[BIT_PC]  = mem_ready;
        Rin[BIT_MDR] = 1'b1;
        MDRread      = 1'b1;
      end
      S_T2: begin
        Rout[BIT_MDR] = 1'b1;
        IRin          = 1'b1;
      end
      S_T3: begin
        if (dec_cls == CLS_3OP) begin
          Rout = 32'd1 << rb;
          RYin = 1'b1;
        end else if (dec_cls == CLS_2OP) begin
          Rout       = 32'd1 << rb;
          ALUControl = dec_alu;
          Rin[BIT_Z] = 1'b1;
        end
      end
      S_T4: begin
        if (dec_cls == CLS_2OP) begin
          Rout[BIT_Z] = 1'b1;
          Rin         = 32'd1 << ra;
        end else begin
          Rout       = 32'd1 << rc;
          ALUControl = dec_alu;
          Rin[BIT_Z] = 1'b1;
        end
      end
      S_T5: begin
        Rout[BIT_Z] = 1'b1;
        Rin         = 32'd1 << ra;
      end
      default: ;
    endcase
  end

  assign busy    = (state_q != S_IDLE) && (state_q != S_HALT);
  assign halted  = (state_q == S_HALT);
  assign illegal = illegal_q;

  logic unused_ir;
  assign unused_ir = ^ir[14:0];

`ifdef DATAPATH_CTRL_RETIRE_COUNT_EN
  logic [RETIRE_W-1:0] retired_q;

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      retired_q <= '0;
    end else if (retire) begin
      retired_q <= retired_q + RETIRE_W'(1);
    end
  end

  assign retired = retired_q;
`else
  logic unused_retire;
  assign unused_retire = retire;
  assign retired       = '0;
`endif

endmodule

// File: tb/tb_datapath_ctrl.sv
// tb/tb_datapath_ctrl.sv - randomized self-checking bench for datapath_ctrl against a phase-table model
module tb_datapath_ctrl;

  localparam int RW = 4;

  logic          clock = 1'b0;
  logic          clear, run, mem_ready;
  logic [31:0]   ir;
  logic [31:0]   Rin, Rout;
  logic          IRin, MARin, RYin, MDRread, busy, halted, illegal;
  logic [15:0]   ALUControl;
  logic [RW-1:0] retired;

  always #5 clock = ~clock;

  datapath_ctrl #(.RETIRE_W(RW)) dut (
    .clock(clock), .clear(clear), .run(run), .ir(ir), .mem_ready(mem_ready),
    .Rin(Rin), .Rout(Rout), .IRin(IRin), .MARin(MARin), .RYin(RYin),
    .ALUControl(ALUControl), .MDRread(MDRread), .busy(busy), .halted(halted),
    .illegal(illegal), .retired(retired)
  );

  typedef struct packed {
    logic [31:0] rin;
    logic [31:0] rout;
    logic        irin, marin, ryin, mdrread;
    logic [15:0] alu;
    logic        busy, halted, illegal;
  } obs_t;

  typedef struct {
    obs_t o;
    logic mr;
  } step_t;

  step_t       exp_q[$];
  int          checks = 0;
  int          passes = 0;
  int unsigned ret_m  = 0;

  function automatic logic [31:0] oh(input int n);
    return 32'd1 << n;
  endfunction

  function automatic logic [15:0] alu_of(input logic [4:0] op);
    case (op)
      5'd0: return 16'd1;
      5'd1: return 16'd2;
      5'd2: return 16'd4;
      5'd3: return 16'd5;
      5'd4: return 16'd3;
      5'd5: return 16'd6;
      default: return 16'd0;
    endcase
  endfunction

  // Expected per-cycle outputs for one instruction, straight from the phase table.
  function automatic void plan(input logic [31:0] instr, input int waits, output bit retires);
    logic [4:0] op = instr[31:27];
    int ra = int'(instr[26:23]);
    int rb = int'(instr[22:19]);
    int rc = int'(instr[18:15]);
    step_t s;
    s.o = '0; s.o.busy = 1; s.mr = 1'($urandom);
    s.o.rout = oh(20); s.o.marin = 1; s.o.rin = oh(19);
    exp_q.push_back(s);
    for (int w = 0; w < waits; w++) begin
      s.o = '0; s.o.busy = 1; s.mr = 1'b0;
      s.o.rout = oh(19); s.o.rin = oh(21); s.o.mdrread = 1;
      exp_q.push_back(s);
    end
    s.o = '0; s.o.busy = 1; s.mr = 1'b1;
    s.o.rout = oh(19); s.o.rin = oh(21) | oh(20); s.o.mdrread = 1;
    exp_q.push_back(s);
    s.o = '0; s.o.busy = 1; s.mr = 1'($urandom);
    s.o.rout = oh(21); s.o.irin = 1;
    exp_q.push_back(s);
    s.o = '0; s.o.busy = 1; s.mr = 1'($urandom);
    retires = 0;
    if (op <= 5'd3) begin
      s.o.rout = oh(rb); s.o.ryin = 1;
      exp_q.push_back(s);
      s.o = '0; s.o.busy = 1;
      s.o.rout = oh(rc); s.o.alu = alu_of(op); s.o.rin = oh(19);
      exp_q.push_back(s);
      s.o = '0; s.o.busy = 1;
      s.o.rout = oh(19); s.o.rin = oh(ra);
      exp_q.push_back(s);
      retires = 1;
    end else if (op <= 5'd5) begin
      s.o.rout = oh(rb); s.o.alu = alu_of(op); s.o.rin = oh(19);
      exp_q.push_back(s);
      s.o = '0; s.o.busy = 1;
      s.o.rout = oh(19); s.o.rin = oh(ra);
      exp_q.push_back(s);
      retires = 1;
    end else begin
      exp_q.push_back(s);
      retires = (op == 5'b11010);
    end
  endfunction

  function automatic obs_t cur();
    return {Rin, Rout, IRin, MARin, RYin, MDRread, ALUControl, busy, halted, illegal};
  endfunction

  task automatic chk_obs(input string tag, input obs_t e);
    obs_t o = cur();
    checks++;
    assert (o === e) passes++;
    else $error("FAIL %s observed=%h expected=%h", tag, o, e);
  endtask

  task automatic chk_ret(input string tag);
    logic [RW-1:0] e;
`ifdef DATAPATH_CTRL_RETIRE_COUNT_EN
    e = RW'(ret_m);
`else
    e = '0;
`endif
    checks++;
    assert (retired === e) passes++;
    else $error("FAIL %s retired observed=%0d expected=%0d", tag, retired, e);
  endtask

  task automatic run_steps(input string name, input int n);
    int k = 0;
    step_t s;
    while (exp_q.size() > 0 && (n < 0 || k < n)) begin
      s = exp_q.pop_front();
      mem_ready = s.mr;
      run = 1'($urandom);
      @(negedge clock);
      chk_obs($sformatf("%s_cyc%0d", name, k), s.o);
      @(posedge clock); #1;
      k++;
    end
  endtask

  task automatic do_instr(input string name, input logic [31:0] instr, input int waits);
    bit r;
    ir = instr;
    plan(instr, waits, r);
    run_steps(name, -1);
    if (r) ret_m++;
    chk_ret({name, "_ret"});
  endtask

  task automatic reset_and_start(input string name);
    clear = 1'b0;
    #1;
    chk_obs({name, "_clear_outs"}, '0);
    ret_m = 0;
    chk_ret({name, "_clear_ret"});
    exp_q.delete();
    @(posedge clock); #1;
    clear = 1'b1;
    run = 1'b1;
    @(posedge clock); #1;
  endtask

  obs_t hx;

  initial begin
    clear = 1'b0; run = 1'b0; mem_ready = 1'b0; ir = '0;
    @(posedge clock); #1;
    chk_obs("reset_outs", '0);
    chk_ret("reset_ret");
    clear = 1'b1;
    @(negedge clock);
    chk_obs("idle_no_run", '0);
    @(posedge clock); #1;
    run = 1'b1;
    @(posedge clock); #1;

    do_instr("add_r1_r2_r3", 32'h00918000, 0);
    do_instr("not_r4_r7_wait3", 32'h22380000, 3);
    for (int i = 0; i < 20; i++) begin
      logic [4:0] op;
      case ($urandom_range(0, 6))
        0: op = 5'd0; 1: op = 5'd1; 2: op = 5'd2; 3: op = 5'd3;
        4: op = 5'd4; 5: op = 5'd5; default: op = 5'b11010;
      endcase
      do_instr($sformatf("rand%0d", i), {op, 27'($urandom)}, int'($urandom_range(0, 2)));
    end

    do_instr("halt", 32'hD8000000, 1);
    hx = '0; hx.halted = 1;
    for (int i = 0; i < 3; i++) begin
      run = 1'(i);
      @(negedge clock);
      chk_obs($sformatf("halt_hold%0d", i), hx);
      @(posedge clock); #1;
    end
    chk_ret("halt_ret");

    reset_and_start("after_halt");
    do_instr("nop", 32'hD0000000, 0);
    do_instr("illegal_op", 32'h70000000, 0);
    hx = '0; hx.halted = 1; hx.illegal = 1;
    for (int i = 0; i < 2; i++) begin
      run = 1'b1;
      @(negedge clock);
      chk_obs($sformatf("illegal_hold%0d", i), hx);
      @(posedge clock); #1;
    end
    chk_ret("illegal_ret");

    reset_and_start("after_illegal");
    ir = 32'h00918000;
    begin
      bit r;
      plan(ir, 1, r);
    end
    run_steps("add_pre_abort", 5);
    reset_and_start("abort_t4");
    do_instr("add_rerun", 32'h00918000, 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
